// File: rtl/sw_cond_pkg.sv
// Shared constants for the switch conditioning path feeding the 4x1 3-bit mux.
// Bit indices name each switch line by the mux field it drives.
package sw_cond_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned NUM_SWITCHES            = 14;

  localparam int unsigned X2 = 13;
  localparam int unsigned X1 = 12;
  localparam int unsigned X0 = 11;
  localparam int unsigned Y2 = 10;
  localparam int unsigned Y1 = 9;
  localparam int unsigned Y0 = 8;
  localparam int unsigned Z2 = 7;
  localparam int unsigned Z1 = 6;
  localparam int unsigned Z0 = 5;
  localparam int unsigned W2 = 4;
  localparam int unsigned W1 = 3;
  localparam int unsigned W0 = 2;
  localparam int unsigned S1 = 1;
  localparam int unsigned S0 = 0;

  // Same bit order as the index constants above, for slicing sw_clean as a whole.
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [2:0] w;
    logic [1:0] sel;
  } mux_fields_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, stability counter, clean level
// and single-cycle rise/fall pulses.
module debounce_channel
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEBOUNCE_CYCLES consecutive mismatching samples: accept the new level.
        clean <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of independent debounced switch channels with a combined change pulse.
module switch_debounce_bank
  import sw_cond_pkg::*;
#(
  parameter int unsigned WIDTH           = NUM_SWITCHES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  // Pulses are already registered, so the OR lands in the same cycle as them.
  always_comb begin
    any_change = |(sw_rise | sw_fall);
  end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Self-checking bench for switch_debounce_bank with DEBOUNCE_CYCLES=4.
module tb_switch_debounce_bank;

  localparam int unsigned W = 14;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;
  logic         any_change;

  switch_debounce_bank #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: hist[j] is the raw value sampled j edges ago; a channel accepts
  // the opposite level when the D samples seen through the 2-stage delay
  // (hist[2]..hist[D+1]) all disagree with its current clean level.
  logic [W-1:0] hist [0:D+1];
  logic [W-1:0] m_clean, m_rise, m_fall;

  task automatic model_step();
    if (!rst_n) begin
      for (int j = 0; j <= int'(D) + 1; j++) hist[j] = '0;
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
    end else begin
      for (int j = int'(D) + 1; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = sw_raw;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < int'(W); i++) begin
        bit settled = 1'b1;
        for (int j = 2; j <= int'(D) + 1; j++)
          if (hist[j][i] == m_clean[i]) settled = 1'b0;
        if (settled) begin
          m_clean[i] = ~m_clean[i];
          if (m_clean[i]) m_rise[i] = 1'b1;
          else            m_fall[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: DUT and model update on the rising edge, compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_clean", 32'(sw_clean), 32'(m_clean));
    chk("model_rise",  32'(sw_rise),  32'(m_rise));
    chk("model_fall",  32'(sw_fall),  32'(m_fall));
    chk("model_any",   32'(any_change), 32'(|(m_rise | m_fall)));
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    sw_raw = '0;
    tick();
    tick();
    chk("reset_clean", 32'(sw_clean), 32'h0);
    rst_n = 1'b1;
  endtask

  // Counts edges until sw_clean[idx]==val (bounded), capturing the pulses seen there.
  task automatic run_until(input int idx, input logic val, output int edges,
                           output logic [W-1:0] rise_at, output logic [W-1:0] fall_at,
                           output logic any_at);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (sw_clean[idx] !== val && edges < 30);
    rise_at = sw_rise;
    fall_at = sw_fall;
    any_at  = any_change;
  endtask

  typedef struct {
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [W-1:0] raw, logic [W-1:0] c,
                              logic [W-1:0] ri, logic [W-1:0] fa, logic an);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.clean = c; v.rise = ri; v.fall = fa; v.any = an;
    vecs.push_back(v);
  endfunction

  initial begin
    int           edges;
    logic [W-1:0] r_at, f_at;
    logic         a_at;
    int           pulses;

    rst_n  = 1'b0;
    sw_raw = '1;

    // Reset hold, release with all switches high, then bit 0 fall and rise.
    for (int k = 0; k < 10; k++) add(1'b0, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    for (int k = 0; k < 5; k++)  add(1'b1, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    add(1'b1, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000, 1'b1);
    add(1'b1, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000, 1'b0);
    for (int k = 0; k < 5; k++)  add(1'b1, 14'h3FFE, 14'h3FFF, 14'h0000, 14'h0000, 1'b0);
    add(1'b1, 14'h3FFE, 14'h3FFE, 14'h0000, 14'h0001, 1'b1);
    add(1'b1, 14'h3FFE, 14'h3FFE, 14'h0000, 14'h0000, 1'b0);
    for (int k = 0; k < 5; k++)  add(1'b1, 14'h3FFF, 14'h3FFE, 14'h0000, 14'h0000, 1'b0);
    add(1'b1, 14'h3FFF, 14'h3FFF, 14'h0001, 14'h0000, 1'b1);
    add(1'b1, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000, 1'b0);

    foreach (vecs[k]) begin
      rst_n  = vecs[k].rst_n;
      sw_raw = vecs[k].raw;
      tick();
      chk("vec_clean", 32'(sw_clean),   32'(vecs[k].clean));
      chk("vec_rise",  32'(sw_rise),    32'(vecs[k].rise));
      chk("vec_fall",  32'(sw_fall),    32'(vecs[k].fall));
      chk("vec_any",   32'(any_change), 32'(vecs[k].any));
    end

    // Clean step from 0 on bit 0, then back to 0.
    do_reset();
    sw_raw = 14'h0001;
    run_until(0, 1'b1, edges, r_at, f_at, a_at);
    chk("step_rise_edges", 32'(edges), 32'd6);
    chk("step_rise_pulse", 32'(r_at), 32'h0001);
    chk("step_rise_nofall", 32'(f_at), 32'h0);
    tick();
    chk("step_rise_oneshot", 32'(sw_rise), 32'h0);
    sw_raw = 14'h0000;
    run_until(0, 1'b0, edges, r_at, f_at, a_at);
    chk("step_fall_edges", 32'(edges), 32'd6);
    chk("step_fall_pulse", 32'(f_at), 32'h0001);

    // Bounce on bit 13: 1,0,1,0 then hold 1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sw_raw[13] = (k % 2 == 0);
      tick();
      chk("bounce_quiet", 32'(any_change), 32'h0);
    end
    sw_raw[13] = 1'b1;
    run_until(13, 1'b1, edges, r_at, f_at, a_at);
    chk("bounce_edges", 32'(edges), 32'd6);
    chk("bounce_rise", 32'(r_at), 32'h2000);

    // Glitch of 3 cycles on bit 5 must vanish.
    do_reset();
    sw_raw = 14'h0020;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) sw_raw = '0;
      tick();
      if (any_change || sw_clean[5] || sw_rise[5]) pulses++;
    end
    chk("glitch_invisible", 32'(pulses), 32'd0);

    // Simultaneous change on several channels.
    do_reset();
    sw_raw = 14'h2A05;
    run_until(0, 1'b1, edges, r_at, f_at, a_at);
    chk("simul_edges", 32'(edges), 32'd6);
    chk("simul_clean", 32'(sw_clean), 32'h2A05);
    chk("simul_rise", 32'(r_at), 32'h2A05);
    chk("simul_any", 32'(a_at), 32'h1);
    tick();
    chk("simul_any_oneshot", 32'(any_change), 32'h0);

    // Reset in the middle of a pending change on bit 2.
    do_reset();
    sw_raw = 14'h0004;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_async_clean", 32'(sw_clean), 32'h0);
    chk("midrst_async_pulse", 32'(sw_rise | sw_fall), 32'h0);
    tick();
    tick();
    chk("midrst_hold", 32'({sw_clean, sw_rise, sw_fall, any_change}), 32'h0);
    rst_n = 1'b1;
    run_until(2, 1'b1, edges, r_at, f_at, a_at);
    chk("midrst_edges", 32'(edges), 32'd6);
    chk("midrst_rise", 32'(r_at), 32'h0004);

    // Random slow-bouncing traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      sw_raw = sw_raw ^ W'($urandom & $urandom & $urandom);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce_bank.md
Name: switch_debounce_bank

Overview:
- Conditions the raw slide-switch inputs before they reach the multiplexer datapath: X/Y/Z/W data bits and the S1/S0 selects, 14 lines total.
- Per channel:
  - 2-flop synchronizer into the clk domain.
  - Counter-based debounce.
  - Registered clean level, plus one-cycle rise and fall pulses.
- Sits directly upstream of the 4x1 3-bit mux. Its clean levels drive the mux data and select inputs and the select-indicator LEDs.

Parameters:
- WIDTH, 14: number of independent switch channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles required to accept a new level (10 ms at 100 MHz). Legal range is >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width. Derived; do not override.

Ports:
- clk, input, 1: system clock. All state is updated on the rising edge.
- rst_n, input, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is used synchronously to clk.
- sw_raw, input, WIDTH: raw switch pins. These are asynchronous and bouncing.
- sw_clean, output, WIDTH: debounced level per channel.
- sw_rise, output, WIDTH: one-cycle pulse when sw_clean[i] goes 0->1.
- sw_fall, output, WIDTH: one-cycle pulse when sw_clean[i] goes 1->0.
- any_change, output, 1: OR of sw_rise | sw_fall, registered in the same cycle as the pulses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clears both synchronizer flops, counters, sw_clean, sw_rise, sw_fall and any_change to 0.
  - The outputs hold 0 for as long as rst_n is low.
  - After release, a switch already high at reset is accepted as a rising edge after the normal latency.
- Synchronizer: sync1[i] <= sw_raw[i]; sync2[i] <= sync1[i]. No logic between the two flops.
- Counter, per channel, evaluated each edge:
  - sync2 == sw_clean: cnt <= 0.
  - sync2 != sw_clean and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != sw_clean and cnt == DEBOUNCE_CYCLES-1: sw_clean <= sync2 and cnt <= 0.
  - In that same edge, sw_rise <= sync2 and sw_fall <= ~sync2.
- Pulses: sw_rise, sw_fall and any_change are 0 in every cycle except the single cycle after a level is accepted. They never assert together on one channel.
- Latency: a clean raw step that holds still is reflected on sw_clean exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it. The pulse is visible in the same cycle as the new sw_clean.
- Bounce rejection:
  - Any return of sync2 to the current sw_clean value before the count completes resets cnt to 0.
  - No output changes in that case.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is therefore invisible.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous changes on several channels may pulse in the same cycle.
  - any_change is a single pulse covering all of them.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count: cnt is discarded and the pending change is lost. After release the channel restarts from sw_clean=0.

Decomposition:
- Package sw_cond_pkg holds:
  - localparam DEFAULT_DEBOUNCE_CYCLES = 1000000.
  - localparam NUM_SWITCHES = 14.
  - Named bit indices for the mux interface fields: X2..X0, Y2..Y0, Z2..Z0, W2..W0, S1, S0.
- Sub-module debounce_channel:
  - Scope: one channel's synchronizer, counter, level and pulse registers.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, raw, clean, rise, fall.
- The top instantiates it WIDTH times in a generate loop and ORs the pulses into any_change.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=14 unless noted):
- Reset hold: rst_n=0 with sw_raw=14'h3FFF for 10 cycles.
  - All outputs stay 0.
  - Release rst_n: sw_clean=14'h3FFF exactly 6 edges later, with sw_rise=14'h3FFF and any_change=1 for one cycle only.
- Clean step: sw_raw[0] 0->1 held.
  - sw_clean[0]=1 on the 6th sampling edge, sw_rise[0]=1 for one cycle, sw_fall=0.
  - Then drop to 0: sw_fall[0] pulses 6 edges later.
- Bounce: sw_raw[13] toggles 1,0,1,0 on consecutive cycles, then holds 1.
  - No pulse during the toggling.
  - sw_clean[13]=1 exactly 6 edges after the final 0->1 transition.
- Short glitch: sw_raw[5] high for 3 cycles, then low.
  - sw_clean[5], sw_rise[5] and any_change remain 0 throughout.
- Simultaneous: sw_raw 14'h0000 -> 14'h2A05 in one cycle.
  - sw_clean=14'h2A05 and sw_rise=14'h2A05 in the same cycle.
  - any_change is a single one-cycle pulse.
- Reset mid-count: step sw_raw[2] high, assert rst_n after 3 cycles for 2 cycles, keep sw_raw[2]=1.
  - Outputs stay 0 during reset.
  - sw_clean[2]=1 exactly 6 edges after release.
